// File: rtl/audio_sched.sv
// Audio sample scheduler: stereo FIFO drained at SAMPLE_HZ into an HDMI encoder strobe.
// Optional AUDIO_HOLD_EN: repeat the last emitted sample instead of silence on starvation.
module audio_sched #(
    parameter int CLK_HZ     = 74250000,
    parameter int SAMPLE_HZ  = 48000,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wr_l,
    input  logic                  wr_r,
    input  logic [15:0]           wr_data,
    input  logic                  clr_err,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  underrun,
    output logic                  overflow,
    output logic                  audio_w,
    output logic [31:0]           audio
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0]         DEPTH_V   = LW'(DEPTH);
    localparam logic [LW-1:0]         HALF_V    = LW'(DEPTH / 2);
    localparam logic [LW-1:0]         LVL_ZERO  = LW'(0);
    localparam logic [LW-1:0]         LVL_ONE   = LW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic signed [31:0]    STEP_TICK = 32'(SAMPLE_HZ - CLK_HZ);
    localparam logic signed [31:0]    STEP_WAIT = 32'(SAMPLE_HZ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                  state_q;
    logic signed [31:0]      acc_q, acc_d;
    logic [31:0]             mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]           level_q, level_d;
    logic [15:0]             left_q;
    logic [31:0]             audio_q;
    logic                    audio_w_q, full_q, underrun_q, overflow_q;

    logic                    tick_s, pop_s, starve_s, fill_s, push_s, drop_s;
    logic [31:0]             fallback_s;

    // Rate accumulator, FIFO event decode and fallback sample selection
    always_comb begin
        tick_s   = ~acc_q[31];
        acc_d    = acc_q + (tick_s ? STEP_TICK : STEP_WAIT);
        pop_s    = enable && (state_q == S_RUN) && tick_s && (level_q != LVL_ZERO);
        starve_s = enable && (state_q == S_RUN) && tick_s && (level_q == LVL_ZERO);
        fill_s   = enable && (state_q == S_PRIME) && tick_s;
        push_s   = wr_r && (level_q != DEPTH_V);
        drop_s   = wr_r && (level_q == DEPTH_V);
        if (push_s && !pop_s) begin
            level_d = level_q + LVL_ONE;
        end else if (pop_s && !push_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
`ifdef AUDIO_HOLD_EN
        fallback_s = audio_q;
`else
        fallback_s = 32'h0000_0000;
`endif
    end

    // Pair storage; contents are invalidated through the pointers, not cleared
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {wr_data, left_q};
        end
    end

    // Scheduler FSM, FIFO bookkeeping and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= 32'sd0;
            wr_ptr_q   <= PTR_ZERO;
            rd_ptr_q   <= PTR_ZERO;
            level_q    <= LVL_ZERO;
            full_q     <= 1'b0;
            left_q     <= 16'h0000;
            audio_q    <= 32'h0000_0000;
            audio_w_q  <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            level_q <= level_d;
            full_q  <= (level_d == DEPTH_V);
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (wr_l) begin
                left_q <= wr_data;
            end

            audio_w_q <= pop_s || starve_s || fill_s;
            if (pop_s) begin
                audio_q <= mem_q[rd_ptr_q];
            end else if (starve_s || fill_s) begin
                audio_q <= fallback_s;
            end

            // Set events win over a same-cycle clear
            if (starve_s) begin
                underrun_q <= 1'b1;
            end else if (clr_err) begin
                underrun_q <= 1'b0;
            end
            if (drop_s) begin
                overflow_q <= 1'b1;
            end else if (clr_err) begin
                overflow_q <= 1'b0;
            end

            if (!enable) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE:  state_q <= S_PRIME;
                    S_PRIME: state_q <= (level_q >= HALF_V) ? S_RUN : S_PRIME;
                    S_RUN:   state_q <= starve_s ? S_PRIME : S_RUN;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign level    = level_q;
    assign full     = full_q;
    assign underrun = underrun_q;
    assign overflow = overflow_q;
    assign audio_w  = audio_w_q;
    assign audio    = audio_q;

endmodule
